// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes and the
// adapter state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
        S_DONE
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering: extracts and extends a load value from a
// memory word, and merges sub-word store data into a read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(word >> {offset, 3'b000});
    assign half_v = 16'(word >> {offset[1], 4'b0000});

    always_comb begin
        load_val = word;
        case (funct3)
            F3_B:    load_val = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_val = {{16{half_v[15]}}, half_v};
            F3_BU:   load_val = {24'd0, byte_v};
            F3_HU:   load_val = {16'd0, half_v};
            default: load_val = word;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the word is preserved.
    always_comb begin
        merged_word = word;
        case (funct3)
            F3_B:    merged_word[{offset, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    merged_word = wdata;
            default: merged_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_adapter.sv
// RV32I load/store unit front-end for a word-addressed data memory with
// read-modify-write for sub-word stores and an optional ack timeout.
module lsu_mem_adapter
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] tcnt;
    logic [31:0] load_val;
    logic [31:0] merged_word;
    logic        req_ok;
    logic        timed_out;

    lsu_align u_align (
        .word        (mem_data_i),
        .offset      (offset_q),
        .funct3      (f3_q),
        .wdata       (wdata_q),
        .load_val    (load_val),
        .merged_word (merged_word)
    );

    // Stores only have B/H/W widths; the unsigned codes are loads only.
    always_comb begin
        req_ok = 1'b0;
        case (funct3_i)
            F3_B:    req_ok = 1'b1;
            F3_H:    req_ok = ~addr_i[0];
            F3_W:    req_ok = (addr_i[1:0] == 2'b00);
            F3_BU:   req_ok = ~we_i;
            F3_HU:   req_ok = ~we_i & ~addr_i[0];
            default: req_ok = 1'b0;
        endcase
    end

    assign timed_out = (ACK_TIMEOUT != 0) && (tcnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            f3_q        <= 3'd0;
            offset_q    <= 2'd0;
            wdata_q     <= 32'd0;
            tcnt        <= 32'd0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= 32'd0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_data_o  <= 32'd0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        f3_q     <= funct3_i;
                        offset_q <= addr_i[1:0];
                        wdata_q  <= wdata_i;
                        tcnt     <= 32'd0;
                        if (!req_ok) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            busy_o     <= 1'b1;
                            mem_addr_o <= {addr_i[31:2], 2'b00};
                            if (!we_i) begin
                                state       <= S_RD;
                                mem_rd_en_o <= 1'b1;
                            end else if (funct3_i == F3_W) begin
                                state       <= S_WR;
                                mem_wr_en_o <= 1'b1;
                                mem_data_o  <= wdata_i;
                            end else begin
                                state       <= S_RMW_RD;
                                mem_rd_en_o <= 1'b1;
                            end
                        end
                    end
                end
                S_RD, S_RMW_RD: begin
                    if (mem_ack_i) begin
                        mem_rd_en_o <= 1'b0;
                        tcnt        <= 32'd0;
                        if (state == S_RD) begin
                            rdata_o    <= load_val;
                            state      <= S_DONE;
                            done_o     <= 1'b1;
                            busy_o     <= 1'b0;
                            mem_addr_o <= 32'd0;
                        end else begin
                            state       <= S_WR;
                            mem_wr_en_o <= 1'b1;
                            mem_data_o  <= merged_word;
                        end
                    end else if (timed_out) begin
                        state       <= S_DONE;
                        done_o      <= 1'b1;
                        err_o       <= 1'b1;
                        busy_o      <= 1'b0;
                        mem_rd_en_o <= 1'b0;
                        mem_addr_o  <= 32'd0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                S_WR: begin
                    if (mem_ack_i || timed_out) begin
                        state       <= S_DONE;
                        done_o      <= 1'b1;
                        err_o       <= ~mem_ack_i;
                        busy_o      <= 1'b0;
                        mem_wr_en_o <= 1'b0;
                        mem_addr_o  <= 32'd0;
                        mem_data_o  <= 32'd0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
